bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter DATA_W, 32, BRAM data width.
REQ-002 Parameter ADDR_W, 32, BRAM address width.
REQ-003 Parameter DEPTH, 98304, BRAM words; addresses wrap modulo DEPTH.
REQ-004 Parameter MEM_LATENCY, 2, cycles from address-sampling edge to douta valid at the BRAM output.
REQ-005 Parameter FIFO_DEPTH, 4, output buffer entries; FIFO_DEPTH SHALL be at least MEM_LATENCY+1.
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle request; sampled only in IDLE.
REQ-009 base_addr  in  ADDR_W  first word address, latched on accepted start.
REQ-010 length  in  32  word count, latched on accepted start.
REQ-011 busy  out  1  high from accepted start until done.
REQ-012 done  out  1  one-cycle pulse at transfer end.
REQ-013 mem_addr  out  ADDR_W  BRAM address (connects to addra).
REQ-014 mem_en  out  1  high when mem_addr carries a valid read.
REQ-015 mem_we  out  1  BRAM write enable, constant 0.
REQ-016 mem_dout  in  DATA_W  BRAM read data (connects to douta).
REQ-017 m_data  out  DATA_W  stream data.
REQ-018 m_valid  out  1  stream data valid.
REQ-019 m_ready  in  1  downstream accept; beat transfers when m_valid and m_ready high on a rising edge.
REQ-020 m_last  out  1  high with the final beat only.

Function
REQ-021 States IDLE, READ, DRAIN, DONE; IDLE->READ on start with length>0; IDLE->DONE on start with length==0.
REQ-022 READ: issue a read (mem_en=1, mem_addr=next address) only when in-flight reads plus FIFO occupancy < FIFO_DEPTH; address increments by 1, DEPTH-1 wraps to 0.
REQ-023 READ->DRAIN in the cycle the length-th read is issued.
REQ-024 Each issued read SHALL be tracked by a MEM_LATENCY-deep valid shift register; mem_dout is pushed into the FIFO on the edge MEM_LATENCY cycles after the read's address edge.
REQ-025 FIFO SHALL never overflow; no read data SHALL be dropped or duplicated under any m_ready pattern.
REQ-026 m_data/m_valid driven from FIFO head; m_data stable while m_valid high and m_ready low.
REQ-027 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-028 DRAIN->DONE on the edge the last beat transfers; DONE lasts one cycle (done=1), then IDLE.
REQ-029 busy SHALL be high in READ, DRAIN, DONE; low in IDLE.
REQ-030 start while busy SHALL be ignored, no effect on the transfer.
REQ-031 With m_ready held high, the first m_valid SHALL be high in the cycle after edge 1+MEM_LATENCY (start sampled at edge 0), and beats SHALL follow one per cycle.
REQ-032 length==0: no reads, no beats, done pulses one cycle after start.
REQ-033 length>DEPTH: reads continue through wrap, re-reading from address 0.

Reset
REQ-034 rst SHALL force IDLE, busy=0, done=0, mem_en=0, mem_addr=0, m_valid=0, m_last=0, m_data=0, FIFO empty, in-flight tracker cleared.
REQ-035 rst mid-transfer SHALL abort; returning data from in-flight reads SHALL be discarded; no done pulse.

Verification
REQ-036 BRAM model preloaded mem[i]=i, MEM_LATENCY=2; start, base=0, length=10, m_ready=1 -> m_valid first high after edge 3, data 0..9 on consecutive cycles, m_last with 9, done one cycle after the 9 beat.
REQ-037 base=98300, length=8 -> data 98300..98303,0,1,2,3; mem_addr wraps 98303->0.
REQ-038 length=100, m_ready random 30% duty -> all 100 values in order, no gaps/duplicates, FIFO occupancy never exceeds 4, mem_en stalls while full.
REQ-039 length=0 -> no mem_en, no m_valid, done one cycle after start, busy high exactly one cycle.
REQ-040 length=50, rst asserted after 20 beats, then new start base=0, length=5 -> outputs at reset values after rst edge, second transfer yields exactly 0..4 with no stale data.
REQ-041 start pulsed during busy -> ignored; transfer count and done timing unchanged.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Streams a contiguous (wrapping) range of BRAM words out of a fixed-latency
// read port onto a ready/valid stream. A small FIFO absorbs back-pressure.
module bram_stream_reader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 98304,
    parameter int MEM_LATENCY = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   next_addr;
    logic [31:0]         reads_left;
    logic [31:0]         beats_left;
    logic [CNT_W-1:0]    out_cnt;
    logic [CNT_W-1:0]    fifo_cnt;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [MEM_LATENCY:0] vld_pipe;

    logic              pop;
    logic              push;
    logic              room;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // out_cnt covers every read from issue until its beat leaves the FIFO,
    // so bounding it by FIFO_DEPTH makes overflow impossible. Crediting the
    // pop happening on this same edge keeps full throughput with ready high.
    assign pop        = m_valid & m_ready;
    assign push       = vld_pipe[MEM_LATENCY];
    assign room       = (out_cnt - CNT_W'(pop)) < FIFO_FULL;
    assign issue      = (state == IDLE && start && length != 32'd0) ||
                        (state == READ && reads_left != 32'd0 && room);
    assign issue_addr = (state == IDLE) ? base_addr : next_addr;

    assign m_valid = (fifo_cnt != '0);
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (beats_left == 32'd1);
    assign mem_we  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            next_addr  <= '0;
            reads_left <= '0;
            beats_left <= '0;
            out_cnt    <= '0;
            vld_pipe   <= '0;
        end else begin
            mem_en   <= issue;
            if (issue) begin
                mem_addr  <= issue_addr;
                next_addr <= addr_inc(issue_addr);
            end
            // bit 0 mirrors mem_en; the read data is at the BRAM output
            // when its bit reaches the top of the pipe
            vld_pipe <= {vld_pipe[MEM_LATENCY-1:0], issue};
            out_cnt  <= out_cnt + CNT_W'(issue) - CNT_W'(pop);
            if (pop)
                beats_left <= beats_left - 32'd1;
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        beats_left <= length;
                        if (length == 32'd0) begin
                            reads_left <= '0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end else begin
                            reads_left <= length - 32'd1;
                            state      <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue)
                        reads_left <= reads_left - 32'd1;
                    if (reads_left == 32'd0 || (issue && reads_left == 32'd1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && beats_left == 32'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_dout;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a latency-2 BRAM model whose
// contents are mem[i] = i.
module tb_bram_stream_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 98304;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [31:0]       length = '0;
    logic              busy, done, mem_en, mem_we, m_valid, m_last;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout, m_data;

    int total = 0;
    int bad = 0;

    logic [31:0] beats[$];
    bit          lasts[$];
    logic [31:0] addrs[$];
    int          done_cnt = 0;
    int          out_model = 0;
    int          max_out = 0;

    always #5 clk = ~clk;

    bram_stream_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .MEM_LATENCY(MEM_LAT), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .mem_addr(mem_addr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_dout(mem_dout),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    // Contents equal the address, so the model just delays mem_addr.
    logic [DATA_W-1:0] rd_p [MEM_LAT];
    always @(posedge clk) begin
        rd_p[0] <= mem_en ? mem_addr : 32'hdeadbeef;
        for (int i = 1; i < MEM_LAT; i++)
            rd_p[i] <= rd_p[i-1];
    end
    assign mem_dout = rd_p[MEM_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            out_model = 0;
        end else begin
            if (m_valid && m_ready) begin
                beats.push_back(m_data);
                lasts.push_back(m_last);
            end
            if (mem_en) addrs.push_back(mem_addr);
            if (done) done_cnt++;
            out_model = out_model + (mem_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (out_model > max_out) max_out = out_model;
        end
    end

    task automatic clear_logs();
        beats.delete(); lasts.delete(); addrs.delete();
        done_cnt = 0; max_out = 0;
    endtask

    // Returns at the negedge right after the edge that sampled start.
    task automatic pulse_start(input logic [31:0] b, input logic [31:0] l);
        @(negedge clk);
        start = 1'b1; base_addr = b; length = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total += 8;
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        if (mem_en !== 1'b0)   begin bad++; $display("FAIL reset_mem_en got=%0b want=0", mem_en); end
        if (mem_we !== 1'b0)   begin bad++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
        if (mem_addr !== '0)   begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
        if (m_valid !== 1'b0)  begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        if (m_last !== 1'b0)   begin bad++; $display("FAIL reset_m_last got=%0b want=0", m_last); end
        if (m_data !== '0)     begin bad++; $display("FAIL reset_m_data got=%0d want=0", m_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ev, el, ed, eb;
        m_ready = 1'b1;
        clear_logs();
        pulse_start(32'd0, 32'd10);
        total += 2;
        if (mem_en !== 1'b1) begin bad++; $display("FAIL basic_first_en got=%0b want=1", mem_en); end
        if (mem_addr !== 32'd0) begin bad++; $display("FAIL basic_first_addr got=%0d want=0", mem_addr); end
        for (int k = 0; k <= 14; k++) begin
            ev = (k >= 3 && k <= 12); el = (k == 12); ed = (k == 13); eb = (k <= 13);
            total += 4;
            if (m_valid !== ev) begin bad++; $display("FAIL basic_valid c%0d got=%0b want=%0b", k, m_valid, ev); end
            if (m_last !== el)  begin bad++; $display("FAIL basic_last c%0d got=%0b want=%0b", k, m_last, el); end
            if (done !== ed)    begin bad++; $display("FAIL basic_done c%0d got=%0b want=%0b", k, done, ed); end
            if (busy !== eb)    begin bad++; $display("FAIL basic_busy c%0d got=%0b want=%0b", k, busy, eb); end
            if (ev) begin
                total++;
                if (m_data !== 32'(k - 3)) begin bad++; $display("FAIL basic_data c%0d got=%0d want=%0d", k, m_data, k - 3); end
            end
            @(negedge clk);
        end
        total++;
        if (addrs.size() != 10) begin bad++; $display("FAIL basic_reads got=%0d want=10", addrs.size()); end
    endtask

    task automatic test_wrap();
        bit seen;
        logic [31:0] e;
        m_ready = 1'b1;
        clear_logs();
        pulse_start(32'd98300, 32'd8);
        wait_done(200, seen);
        @(negedge clk);
        total += 3;
        if (!seen) begin bad++; $display("FAIL wrap_done_timeout got=0 want=1"); end
        if (beats.size() != 8) begin bad++; $display("FAIL wrap_count got=%0d want=8", beats.size()); end
        if (addrs.size() != 8) begin bad++; $display("FAIL wrap_reads got=%0d want=8", addrs.size()); end
        for (int i = 0; i < 8 && i < beats.size() && i < addrs.size(); i++) begin
            e = 32'((98300 + i) % DEPTH);
            total += 3;
            if (beats[i] !== e) begin bad++; $display("FAIL wrap_data[%0d] got=%0d want=%0d", i, beats[i], e); end
            if (addrs[i] !== e) begin bad++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", i, addrs[i], e); end
            if (lasts[i] !== (i == 7)) begin bad++; $display("FAIL wrap_last[%0d] got=%0b want=%0b", i, lasts[i], i == 7); end
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        int nl = 0;
        clear_logs();
        m_ready = 1'b0;
        pulse_start(32'd200, 32'd100);
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (done) seen = 1'b1;
            else begin
                m_ready = ($urandom_range(0, 9) < 3);
                @(negedge clk);
            end
        end
        m_ready = 1'b1;
        @(negedge clk);
        total += 4;
        if (!seen) begin bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
        if (beats.size() != 100) begin bad++; $display("FAIL bp_count got=%0d want=100", beats.size()); end
        if (max_out !== 4) begin bad++; $display("FAIL bp_max_outstanding got=%0d want=4", max_out); end
        if (addrs.size() != 100) begin bad++; $display("FAIL bp_reads got=%0d want=100", addrs.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            total++;
            if (beats[i] !== 32'(200 + i)) begin bad++; $display("FAIL bp_data[%0d] got=%0d want=%0d", i, beats[i], 200 + i); end
            if (lasts[i]) nl++;
        end
        total += 2;
        if (nl != 1) begin bad++; $display("FAIL bp_last_count got=%0d want=1", nl); end
        if (lasts.size() == 100 && lasts[99] !== 1'b1) begin bad++; $display("FAIL bp_last_pos got=0 want=1"); end
    endtask

    task automatic test_zero_len();
        m_ready = 1'b1;
        clear_logs();
        pulse_start(32'd7, 32'd0);
        total += 4;
        if (done !== 1'b1)    begin bad++; $display("FAIL zero_done got=%0b want=1", done); end
        if (busy !== 1'b1)    begin bad++; $display("FAIL zero_busy got=%0b want=1", busy); end
        if (mem_en !== 1'b0)  begin bad++; $display("FAIL zero_mem_en got=%0b want=0", mem_en); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL zero_valid got=%0b want=0", m_valid); end
        @(negedge clk);
        total += 2;
        if (done !== 1'b0) begin bad++; $display("FAIL zero_done_after got=%0b want=0", done); end
        if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after got=%0b want=0", busy); end
        repeat (5) @(negedge clk);
        total += 3;
        if (addrs.size() != 0) begin bad++; $display("FAIL zero_reads got=%0d want=0", addrs.size()); end
        if (beats.size() != 0) begin bad++; $display("FAIL zero_beats got=%0d want=0", beats.size()); end
        if (done_cnt != 1)     begin bad++; $display("FAIL zero_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        m_ready = 1'b1;
        clear_logs();
        pulse_start(32'd0, 32'd50);
        for (int c = 0; c < 200 && beats.size() < 20; c++) @(negedge clk);
        total++;
        if (beats.size() < 20) begin bad++; $display("FAIL rm_reach20 got=%0d want=20", beats.size()); end
        rst = 1'b1;
        @(negedge clk);
        total += 6;
        if (busy !== 1'b0)    begin bad++; $display("FAIL rm_busy got=%0b want=0", busy); end
        if (mem_en !== 1'b0)  begin bad++; $display("FAIL rm_mem_en got=%0b want=0", mem_en); end
        if (mem_addr !== '0)  begin bad++; $display("FAIL rm_mem_addr got=%0d want=0", mem_addr); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b want=0", m_valid); end
        if (m_last !== 1'b0)  begin bad++; $display("FAIL rm_last got=%0b want=0", m_last); end
        if (m_data !== '0)    begin bad++; $display("FAIL rm_data got=%0d want=0", m_data); end
        rst = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        total += 2;
        if (beats.size() != 0) begin bad++; $display("FAIL rm_stale_beats got=%0d want=0", beats.size()); end
        if (done_cnt != 0)     begin bad++; $display("FAIL rm_spurious_done got=%0d want=0", done_cnt); end
        pulse_start(32'd0, 32'd5);
        wait_done(100, seen);
        @(negedge clk);
        total += 3;
        if (!seen) begin bad++; $display("FAIL rm_done_timeout got=0 want=1"); end
        if (beats.size() != 5) begin bad++; $display("FAIL rm_count got=%0d want=5", beats.size()); end
        if (done_cnt != 1)     begin bad++; $display("FAIL rm_done_cnt got=%0d want=1", done_cnt); end
        for (int i = 0; i < beats.size(); i++) begin
            total++;
            if (beats[i] !== 32'(i)) begin bad++; $display("FAIL rm_data[%0d] got=%0d want=%0d", i, beats[i], i); end
        end
    endtask

    task automatic test_start_busy();
        int done_k = -1;
        m_ready = 1'b1;
        clear_logs();
        pulse_start(32'd0, 32'd10);
        for (int k = 0; k <= 14; k++) begin
            if (k == 2 || k == 5) begin
                start = 1'b1; base_addr = 32'd500; length = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done && done_k < 0) done_k = k;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        total += 5;
        if (done_k != 13)       begin bad++; $display("FAIL sb_done_cycle got=%0d want=13", done_k); end
        if (done_cnt != 1)      begin bad++; $display("FAIL sb_done_cnt got=%0d want=1", done_cnt); end
        if (beats.size() != 10) begin bad++; $display("FAIL sb_count got=%0d want=10", beats.size()); end
        if (addrs.size() != 10) begin bad++; $display("FAIL sb_reads got=%0d want=10", addrs.size()); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL sb_busy_end got=%0b want=0", busy); end
        for (int i = 0; i < beats.size(); i++) begin
            total++;
            if (beats[i] !== 32'(i)) begin bad++; $display("FAIL sb_data[%0d] got=%0d want=%0d", i, beats[i], i); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_start_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
